// File: rtl/alu_pkg.sv
// Function codes and decode helpers shared by the ALU issue stage and its neighbours.
// The command struct depends on WIDTH, so each instantiating module declares it locally.
package alu_pkg;

    localparam int unsigned FUNC_W = 4;

    localparam logic [FUNC_W-1:0] FN_ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] FN_CMP = 4'b0010;
    localparam logic [FUNC_W-1:0] FN_NEG = 4'b0011;
    localparam logic [FUNC_W-1:0] FN_AND = 4'b0100;
    localparam logic [FUNC_W-1:0] FN_OR  = 4'b0101;
    localparam logic [FUNC_W-1:0] FN_XOR = 4'b0110;
    localparam logic [FUNC_W-1:0] FN_ROL = 4'b0111;
    localparam logic [FUNC_W-1:0] FN_ROR = 4'b1111;

    // Codes 1000-1110 reach the ALU unchanged but are flagged as errors.
    function automatic logic fn_is_defined(input logic [FUNC_W-1:0] func);
        return !func[FUNC_W-1] || (func == FN_ROR);
    endfunction

    // Only add/sub produce a meaningful overflow/sign flag.
    function automatic logic fn_has_flag(input logic [FUNC_W-1:0] func);
        return (func == FN_ADD) || (func == FN_SUB);
    endfunction

endpackage

// File: rtl/sync_cmd_fifo.sv
// Single-clock command FIFO; full/empty come from the entry count, not pointer equality.
module sync_cmd_fifo #(
    parameter int unsigned DATA_W = 68,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_issue.sv
// Registered issue stage around the combinational alu: command FIFO in, result register out.
// The alu path terminates at the result register; alu_* are FIFO head through a mux only.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FUNC_W-1:0] cmd_func,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_r,
    input  logic              alu_ov_sgn,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_flag,
    output logic              res_err,
    output logic [CNT_W-1:0]  occupancy
);

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
    } cmd_t;

    cmd_t                wr_cmd;
    cmd_t                head;
    logic [$bits(cmd_t)-1:0] head_bits;
    logic                push;
    logic                cap;
    logic                not_empty;

    assign not_empty = (occupancy != '0);
    assign cmd_ready = (occupancy != CNT_W'(DEPTH)) && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign cap       = not_empty && (!res_valid || res_ready);
    assign wr_cmd    = '{func: cmd_func, a: cmd_a, b: cmd_b};
    assign head      = cmd_t'(head_bits);

    sync_cmd_fifo #(
        .DATA_W ($bits(cmd_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (cap),
        .wdata (wr_cmd),
        .rdata (head_bits),
        .count (occupancy)
    );

    // Unwritten storage must never leak onto the alu inputs.
    assign alu_a    = not_empty ? head.a    : '0;
    assign alu_b    = not_empty ? head.b    : '0;
    assign alu_func = not_empty ? head.func : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flag  <= 1'b0;
            res_err   <= 1'b0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (cap) begin
            res_valid <= 1'b1;
            res_data  <= alu_r;
            res_flag  <= fn_has_flag(head.func) && alu_ov_sgn;
            res_err   <= !fn_is_defined(head.func);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue with a behavioural alu and reference model.
module tb_alu_issue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_func = '0;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [31:0]      alu_a, alu_b, alu_r;
    logic [3:0]       alu_func;
    logic             alu_ov_sgn;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             res_flag, res_err;
    logic [CNT_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        flag;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic        held_valid = 1'b0;
    logic [31:0] held_data;
    logic        held_flag, held_err;

    always #5 clk = ~clk;

    alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_func   (cmd_func),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_r      (alu_r),
        .alu_ov_sgn (alu_ov_sgn),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_flag   (res_flag),
        .res_err    (res_err),
        .occupancy  (occupancy)
    );

    // Behavioural alu: {flag, r}. Add/sub flag is carry/borrow; other codes give parity so
    // that the stage's masking is observable. Undefined codes alias onto the low three bits.
    function automatic logic [32:0] alu_fn(input logic [3:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] d;
        logic [31:0] r;
        case (f)
            4'b0000: return {1'b0, a} + {1'b0, b};
            4'b0001: return {(a < b), a - b};
            4'b0010: r = {29'd0, (a > b), (a < b), (a == b)};
            4'b0011: r = -a;
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: begin d = {a, a} << b[4:0]; r = d[63:32]; end
            4'b1111: begin d = {a, a} >> b[4:0]; r = d[31:0]; end
            default: return alu_fn({1'b0, f[2:0]}, a, b);
        endcase
        return {^r, r};
    endfunction

    assign {alu_ov_sgn, alu_r} = alu_fn(alu_func, alu_a, alu_b);

    function automatic exp_t expect_of(input logic [3:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        exp_t        x;
        logic [32:0] v;
        v      = alu_fn(f, a, b);
        x.data = v[31:0];
        x.flag = (f == 4'b0000 || f == 4'b0001) ? v[32] : 1'b0;
        x.err  = (f >= 4'b1000 && f <= 4'b1110);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: decides at the negedge what the coming edge will transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("stall_data", res_data, held_data);
                check("stall_flag", {31'd0, res_flag}, {31'd0, held_flag});
                check("stall_err", {31'd0, res_err}, {31'd0, held_err});
                check("stall_valid", {31'd0, res_valid}, 32'd1);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_flag", {31'd0, res_flag}, {31'd0, e.flag});
                        check("res_err", {31'd0, res_err}, {31'd0, e.err});
                    end
                end
                if (cmd_valid && cmd_ready) sb.push_back(expect_of(cmd_func, cmd_a, cmd_b));
            end
            held_valid = res_valid && !res_ready && !flush;
            held_data  = res_data;
            held_flag  = res_flag;
            held_err   = res_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        bit acc;
        n = 0;
        cmd_valid = 1'b1;
        cmd_func  = f;
        cmd_a     = a;
        cmd_b     = b;
        do begin
            acc = cmd_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        cmd_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        exp_t first;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_flag_err", {30'd0, res_flag, res_err}, 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_alu", alu_a | alu_b | {28'd0, alu_func}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Add with carry, one-cycle latency
        res_ready = 1'b1;
        send(4'b0000, 32'hFFFF_FFFF, 32'd1);
        check("lat_valid_k", {31'd0, res_valid}, 32'd0);
        check("lat_occ_k", 32'(occupancy), 32'd1);
        check("head_alu_a", alu_a, 32'hFFFF_FFFF);
        tick();
        check("lat_valid_k1", {31'd0, res_valid}, 32'd1);
        check("add_data", res_data, 32'd0);
        check("add_flag", {31'd0, res_flag}, 32'd1);
        check("add_err", {31'd0, res_err}, 32'd0);
        tick();

        // Sub then rotate-right, back to back
        send(4'b0001, 32'd3, 32'd5);
        send(4'b1111, 32'd1, 32'd1);
        check("sub_data", res_data, 32'hFFFF_FFFE);
        check("sub_flag", {31'd0, res_flag}, 32'd1);
        tick();
        check("ror_data", res_data, 32'h8000_0000);
        check("ror_flag", {31'd0, res_flag}, 32'd0);
        tick();

        // Fill while stalled
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'b0110, 32'h1000 + 32'(i), 32'h0F0F_0F0F);
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_ready", {31'd0, cmd_ready}, 32'd0);
        check("full_head_data", res_data, 32'h1000 ^ 32'h0F0F_0F0F);
        repeat (3) tick();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_valid", {31'd0, res_valid}, 32'd1);
            check("drain_occ", 32'(occupancy), 32'(3 - i));
        end
        tick();
        check("drain_done", {31'd0, res_valid}, 32'd0);

        // Undefined code
        send(4'b1010, 32'd7, 32'd2);
        tick();
        check("undef_err", {31'd0, res_err}, 32'd1);
        check("undef_flag", {31'd0, res_flag}, 32'd0);
        tick();

        // Flush with queued commands and a pending result
        res_ready = 1'b0;
        first = expect_of(4'b0000, 32'd10, 32'd20);
        send(4'b0000, 32'd10, 32'd20);
        for (int i = 0; i < 3; i++) send(4'b0101, 32'(i), 32'h100);
        check("pre_flush_occ", 32'(occupancy), 32'd3);
        check("pre_flush_valid", {31'd0, res_valid}, 32'd1);
        cmd_valid = 1'b1;
        cmd_func  = 4'b0100;
        cmd_a     = 32'hDEAD_BEEF;
        cmd_b     = 32'hFFFF_FFFF;
        flush     = 1'b1;
        #1;
        check("flush_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_valid", {31'd0, res_valid}, 32'd0);
        check("flush_data_kept", res_data, first.data);
        tick();
        check("flush_dropped", 32'(occupancy), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(3) != 0);
            cmd_func  = 4'($urandom_range(15));
            cmd_a     = $urandom();
            cmd_b     = $urandom();
            res_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(49) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        flush     = 1'b0;
        res_ready = 1'b1;
        repeat (8) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-stream
        res_ready = 1'b0;
        send(4'b0000, 32'd1, 32'd2);
        send(4'b0000, 32'd3, 32'd4);
        check("pre_rst_valid", {31'd0, res_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, res_valid}, 32'd0);
        check("async_rst_occ", 32'(occupancy), 32'd0);
        check("async_rst_alu", alu_a | alu_b, 32'd0);
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        send(4'b0111, 32'h8000_0001, 32'd4);
        repeat (3) tick();
        check("post_rst_sb", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
